char_lcd_ctrl: RTL and testbench

//  Parametrised HD44780-style character-LCD controller with an internal ROWS x COLS character buffer.
//  It runs power-up init once, then continuously refreshes the panel from the buffer.
//  A host (calculator datapath, keypad decoder) writes characters by row/col at any time.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_char_buf.sv | 71 +++++++
 rtl/char_lcd_ctrl.sv | 159 +++++++++++++++
 tb/tb_char_lcd_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD controller:
//   - HD44780 command bytes used by the init sequence and refresh loop
//   - controller FSM state encoding (3 bits, exported on dbg_state)
//   - ddram_addr(): "set DDRAM address" command for the start of a row
package lcd_pkg;

  localparam logic [7:0] FUNC_8B_2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] DISP_ON    = 8'h0C;  // display on, cursor off, blink off
  localparam logic [7:0] ENTRY_INC  = 8'h06;  // auto-increment address, no shift
  localparam logic [7:0] CLR        = 8'h01;  // clear display
  localparam logic [7:0] SET_DDRAM  = 8'h80;  // set DDRAM address (OR in address)
  localparam logic [7:0] ROW1_BASE  = 8'h40;  // DDRAM base of the second row
  localparam logic [7:0] SPACE      = 8'h20;  // blank character

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    FUNC  = 3'd1,
    DISP  = 3'd2,
    ENTRY = 3'd3,
    CLEAR = 3'd4,
    ADDR  = 3'd5,
    DATA  = 3'd6,
    GAP   = 3'd7
  } lcd_state_t;

  function automatic logic [7:0] ddram_addr(input logic row);
    return SET_DDRAM | (row ? ROW1_BASE : 8'h00);
  endfunction

endpackage

// File: rtl/lcd_char_buf.sv
// ROWS x COLS character buffer for the LCD controller.
// Ports:
//   clk, rst           clock, asynchronous active-low reset (buffer -> all spaces)
//   wr_en/wr_row/wr_col/wr_char   host write port
//   clr_req            pulse: fill the buffer with spaces, one cell per clk
//   wr_ready           1 = host writes are accepted (low while clearing)
//   rd_row/rd_col      read address from the refresh FSM
//   rd_char            asynchronous read data
//
// Write handshake: a write is taken on the clk edge where wr_en && wr_ready,
// the target lies inside the ROWS x COLS geometry and no clr_req is present.
// There is no stall: a write offered while wr_ready=0 (or out of range, or
// colliding with clr_req) is dropped, never held for later.
module lcd_char_buf
  import lcd_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 16,
  parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [7:0]    wr_char,
  input  logic          clr_req,
  output logic          wr_ready,
  input  logic          rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [7:0]    rd_char
);

  localparam int N  = ROWS * COLS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  // Stored row-major as a flat array so a single-row panel needs no
  // zero-width row index.
  logic [7:0]    mem [N];
  logic          clearing;
  logic [AW-1:0] clr_idx;
  logic          wr_ok;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign wr_ready = ~clearing;
  assign wr_ok    = wr_en && wr_ready && !clr_req &&
                    (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign wr_addr  = AW'(int'(wr_row) * COLS + int'(wr_col));
  assign rd_addr  = AW'(int'(rd_row) * COLS + int'(rd_col));
  assign rd_char  = mem[rd_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) mem[i] <= SPACE;
      clearing <= 1'b0;
      clr_idx  <= '0;
    end else if (clr_req) begin
      // A new request always restarts the fill from cell 0.
      clearing <= 1'b1;
      clr_idx  <= '0;
    end else if (clearing) begin
      mem[clr_idx] <= SPACE;
      if (int'(clr_idx) == N - 1) clearing <= 1'b0;
      else                        clr_idx  <= clr_idx + 1'b1;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_char;
    end
  end

endmodule

// File: rtl/char_lcd_ctrl.sv
// HD44780-style character-LCD controller with an internal character buffer.
// Runs the power-up init sequence once, then refreshes the whole panel from
// the buffer forever: ADDR(row) + COLS data writes per row, then an idle gap.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   wr_en/wr_row/wr_col/wr_char   host character write
//   clr_req            pulse: blank the buffer
//   wr_ready           1 = buffer accepts writes
//   init_done          1 once the init sequence has completed
//   lcd_e              enable strobe, period 2*CLK_DIV clk
//   lcd_rs/lcd_rw/lcd_data   LCD bus, changed only when lcd_e falls
//   dbg_state          current FSM state (lcd_state_t encoding)
module char_lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_DIV     = 5,
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int INIT_DELAY  = 70,
  parameter int CMD_TICKS   = 30,
  parameter int CLR_TICKS   = 200,
  parameter int REFRESH_GAP = 400,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [7:0]    wr_char,
  input  logic          clr_req,
  output logic          wr_ready,
  output logic          init_done,
  output logic          lcd_e,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic [7:0]    lcd_data,
  output logic [2:0]    dbg_state
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          div_tc;
  logic          step;
  lcd_state_t    state;
  logic [15:0]   tick;
  logic          row;
  logic [CW-1:0] col;
  logic [CW-1:0] rd_col;
  logic [7:0]    rd_char;

  assign dbg_state = state;

  // ---------------- E divider ----------------
  assign div_tc = (int'(div_cnt) == CLK_DIV - 1);
  // Bus and FSM advance where E falls, so the bus is settled for the whole
  // following E-high phase.
  assign step   = div_tc && lcd_e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      lcd_e   <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= '0;
      lcd_e   <= ~lcd_e;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------- character buffer ----------------
  // The data byte is registered at the step that enters the cell, so the
  // read address is the cell about to be shown: col 0 from ADDR, col+1 in DATA.
  assign rd_col = (state == DATA && int'(col) != COLS - 1) ? col + 1'b1 : '0;

  lcd_char_buf #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_char (wr_char),
    .clr_req (clr_req),
    .wr_ready(wr_ready),
    .rd_row  (row),
    .rd_col  (rd_col),
    .rd_char (rd_char)
  );

  // ---------------- sequencer ----------------
  function automatic logic tick_last(input int len);
    return int'(tick) == len - 1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PWRUP;
      tick      <= '0;
      row       <= 1'b0;
      col       <= '0;
      lcd_rs    <= 1'b1;
      lcd_rw    <= 1'b1;
      lcd_data  <= 8'h00;
      init_done <= 1'b0;
    end else if (step) begin
      tick <= tick + 1'b1;
      case (state)
        PWRUP: if (tick_last(INIT_DELAY)) begin
          state <= FUNC;  tick <= '0;
          lcd_rs <= 1'b0; lcd_rw <= 1'b0; lcd_data <= FUNC_8B_2L;
        end
        FUNC: if (tick_last(CMD_TICKS)) begin
          state <= DISP;  tick <= '0; lcd_data <= DISP_ON;
        end
        DISP: if (tick_last(CMD_TICKS)) begin
          state <= ENTRY; tick <= '0; lcd_data <= ENTRY_INC;
        end
        ENTRY: if (tick_last(CMD_TICKS)) begin
          state <= CLEAR; tick <= '0; lcd_data <= CLR;
        end
        CLEAR: if (tick_last(CLR_TICKS)) begin
          state <= ADDR;  tick <= '0; row <= 1'b0;
          lcd_data  <= ddram_addr(1'b0);
          init_done <= 1'b1;
        end
        ADDR: begin
          state <= DATA;  tick <= '0; col <= '0;
          lcd_rs <= 1'b1; lcd_data <= rd_char;
        end
        DATA: begin
          if (int'(col) == COLS - 1) begin
            tick <= '0;
            if (int'(row) < ROWS - 1) begin
              state <= ADDR;  row <= 1'b1;
              lcd_rs <= 1'b0; lcd_data <= ddram_addr(1'b1);
            end else begin
              state <= GAP;
              lcd_rw <= 1'b1; lcd_data <= 8'h00;
            end
          end else begin
            col <= col + 1'b1;
            lcd_data <= rd_char;
          end
        end
        GAP: if (tick_last(REFRESH_GAP)) begin
          state <= ADDR;  tick <= '0; row <= 1'b0;
          lcd_rs <= 1'b0; lcd_rw <= 1'b0; lcd_data <= ddram_addr(1'b0);
        end
        default: begin
          state <= PWRUP; tick <= '0;
          lcd_rs <= 1'b1; lcd_rw <= 1'b1; lcd_data <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_lcd_ctrl.sv
// Directed bench for char_lcd_ctrl. dut0: 2x4 panel, dut1: 1x5 panel (used
// for out-of-range write drops). Bus values are captured once per E-high as
// {rs, rw, data}.
module tb_char_lcd_ctrl;
  import lcd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       wr_en0, wr_en1, wr_row, clr_req0, clr_req1;
  logic [1:0] wr_col0;
  logic [2:0] wr_col1;
  logic [7:0] wr_char;

  logic       wr_ready0, init_done0, e0, rs0, rw0;
  logic [7:0] d0;
  logic [2:0] st0;
  logic       wr_ready1, init_done1, e1, rs1, rw1;
  logic [7:0] d1;
  logic [2:0] st1;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  char_lcd_ctrl #(.CLK_DIV(2), .COLS(4), .ROWS(2), .INIT_DELAY(3), .CMD_TICKS(2),
                  .CLR_TICKS(2), .REFRESH_GAP(4)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_row(wr_row), .wr_col(wr_col0),
    .wr_char(wr_char), .clr_req(clr_req0), .wr_ready(wr_ready0), .init_done(init_done0),
    .lcd_e(e0), .lcd_rs(rs0), .lcd_rw(rw0), .lcd_data(d0), .dbg_state(st0)
  );

  char_lcd_ctrl #(.CLK_DIV(2), .COLS(5), .ROWS(1), .INIT_DELAY(3), .CMD_TICKS(2),
                  .CLR_TICKS(2), .REFRESH_GAP(4)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_row(wr_row), .wr_col(wr_col1),
    .wr_char(wr_char), .clr_req(clr_req1), .wr_ready(wr_ready1), .init_done(init_done1),
    .lcd_e(e1), .lcd_rs(rs1), .lcd_rw(rw1), .lcd_data(d1), .dbg_state(st1)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver / monitor tasks ----------------
  // Wait for the next rising edge of lcd_e and return the bus shown in that E-high.
  task automatic get_e(input int sel, output logic [9:0] b);
    logic prev, cur, ok;
    ok   = 1'b0;
    prev = (sel == 0) ? e0 : e1;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      cur = (sel == 0) ? e0 : e1;
      if (cur && !prev) ok = 1'b1;
      prev = cur;
    end
    if (!ok) begin
      n_total++;
      n_fail++;
      $error("FAIL e_timeout: observed no lcd_e rise expected one within 64 clk");
    end
    b = (sel == 0) ? {rs0, rw0, d0} : {rs1, rw1, d1};
  endtask

  task automatic find_bus(input int sel, input logic [9:0] target, input int budget,
                          input string tag);
    logic [9:0] b;
    logic       hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      get_e(sel, b);
      if (b === target) hit = 1'b1;
    end
    chk({tag, "_sync"}, 32'(hit), 32'd1);
  endtask

  task automatic do_write(input int sel, input logic r, input int c, input logic [7:0] ch);
    @(negedge clk);
    wr_row  = r;
    wr_col0 = 2'(c);
    wr_col1 = 3'(c);
    wr_char = ch;
    if (sel == 0) wr_en0 = 1'b1;
    else          wr_en1 = 1'b1;
    @(negedge clk);
    wr_en0 = 1'b0;
    wr_en1 = 1'b0;
  endtask

  // One full dut0 frame starting at the next ADDR 80.
  task automatic check_frame0(input string tag, input logic [31:0] r0, input logic [31:0] r1);
    logic [9:0] b;
    find_bus(0, 10'h080, 60, tag);
    for (int c = 0; c < 4; c++) begin
      get_e(0, b);
      chk({tag, "_row0"}, 32'(b), 32'({2'b10, r0[31-8*c -: 8]}));
    end
    get_e(0, b);
    chk({tag, "_addr1"}, 32'(b), 32'h0C0);
    for (int c = 0; c < 4; c++) begin
      get_e(0, b);
      chk({tag, "_row1"}, 32'(b), 32'({2'b10, r1[31-8*c -: 8]}));
    end
    get_e(0, b);
    chk({tag, "_gap"}, 32'(b), 32'h300);
  endtask

  // ---------------- stimulus ----------------
  logic [9:0]  exp_seq [26];
  logic [9:0]  b;
  logic [39:0] exp1;
  int          lo;

  initial begin
    wr_en0 = 1'b0; wr_en1 = 1'b0; wr_row = 1'b0; wr_col0 = '0; wr_col1 = '0;
    wr_char = 8'h00; clr_req0 = 1'b0; clr_req1 = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_e",         32'(e0),         32'd0);
    chk("rst_rs",        32'(rs0),        32'd1);
    chk("rst_rw",        32'(rw0),        32'd1);
    chk("rst_data",      32'(d0),         32'h00);
    chk("rst_init_done", 32'(init_done0), 32'd0);
    chk("rst_wr_ready",  32'(wr_ready0),  32'd1);
    chk("rst_state",     32'(st0),        32'(PWRUP));
    rst = 1'b1;

    // init sequence and the first idle frame
    exp_seq = '{10'h300, 10'h300, 10'h300,
                10'h038, 10'h038, 10'h00C, 10'h00C, 10'h006, 10'h006, 10'h001, 10'h001,
                10'h080, 10'h220, 10'h220, 10'h220, 10'h220,
                10'h0C0, 10'h220, 10'h220, 10'h220, 10'h220,
                10'h300, 10'h300, 10'h300, 10'h300, 10'h080};
    for (int i = 0; i < 26; i++) begin
      get_e(0, b);
      chk($sformatf("seq_%0d", i), 32'(b), 32'(exp_seq[i]));
      if (i == 10) chk("init_done_before", 32'(init_done0), 32'd0);
      if (i == 11) chk("init_done_after",  32'(init_done0), 32'd1);
    end

    // host writes show up in the next refresh
    do_write(0, 1'b0, 1, 8'h37);
    do_write(0, 1'b1, 3, 8'h2B);
    check_frame0("wr2", 32'h20372020, 32'h2020202B);

    // dut1 (1 row x 5 cols): col 5 and row 1 are out of range and dropped
    do_write(1, 1'b0, 2, 8'h37);
    do_write(1, 1'b0, 5, 8'h58);
    do_write(1, 1'b1, 2, 8'h59);
    do_write(1, 1'b1, 0, 8'h5A);
    exp1 = 40'h2020372020;
    find_bus(1, 10'h080, 60, "oob");
    for (int c = 0; c < 5; c++) begin
      get_e(1, b);
      chk("oob_row0", 32'(b), 32'({2'b10, exp1[39-8*c -: 8]}));
    end
    get_e(1, b);
    chk("oob_gap", 32'(b), 32'h300);

    // fill every cell, then clear (clr_req wins over a same-clk write)
    for (int k = 0; k < 8; k++) do_write(0, (k >= 4), k % 4, 8'h41 + 8'(k));
    check_frame0("fill", 32'h41424344, 32'h45464748);
    @(negedge clk);
    clr_req0 = 1'b1; wr_en0 = 1'b1; wr_row = 1'b0; wr_col0 = 2'd0; wr_char = 8'h5A;
    @(negedge clk);
    clr_req0 = 1'b0; wr_en0 = 1'b0;
    chk("clr_ready_next_clk", 32'(wr_ready0), 32'd0);
    lo = 0;
    for (int i = 0; i < 12; i++) begin
      if (!wr_ready0) lo++;
      if (i == 2) begin
        wr_en0 = 1'b1; wr_row = 1'b1; wr_col0 = 2'd2; wr_char = 8'h58;
      end else begin
        wr_en0 = 1'b0;
      end
      @(negedge clk);
    end
    chk("clr_low_cycles", 32'(lo), 32'd8);
    chk("clr_ready_after", 32'(wr_ready0), 32'd1);
    check_frame0("clr", 32'h20202020, 32'h20202020);

    // reset in the middle of row-1 data: same-clk reset values, init re-runs
    do_write(0, 1'b1, 0, 8'h51);
    find_bus(0, 10'h0C0, 60, "mid");
    get_e(0, b);
    chk("mid_row1_col0", 32'(b), 32'h251);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_e",         32'(e0),         32'd0);
    chk("mid_rst_rs",        32'(rs0),        32'd1);
    chk("mid_rst_rw",        32'(rw0),        32'd1);
    chk("mid_rst_data",      32'(d0),         32'h00);
    chk("mid_rst_init_done", 32'(init_done0), 32'd0);
    chk("mid_rst_state",     32'(st0),        32'(PWRUP));
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_e(0, b);
      chk($sformatf("reinit_%0d", i), 32'(b), 32'(exp_seq[i]));
    end
    check_frame0("post_rst", 32'h20202020, 32'h20202020);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
